// File: rtl/spi_flash_reader_if.sv
// Request/response and SPI pin bundle for spi_flash_reader.
// master: the reader itself (SPI master, answers word requests); slave: the requester plus flash side.
interface spi_flash_reader_if;
    logic [23:0] spi_addr;
    logic        spi_rd;
    logic [15:0] spi_data;
    logic        ready;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        miso;

    modport master (
        input  spi_addr, spi_rd, miso,
        output spi_data, ready, cs_n, sclk, mosi
    );

    modport slave (
        output spi_addr, spi_rd, miso,
        input  spi_data, ready, cs_n, sclk, mosi
    );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI mode-0 master fetching one little-endian 16-bit word from serial flash per request.
// Define SPI_FLASH_FAST_READ_EN to issue FAST_READ (0x0B) with 8 dummy bits instead of READ (0x03).
module spi_flash_reader #(
    parameter int CLK_DIV = 1,
    parameter int CS_IDLE = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    spi_flash_reader_if.master bus
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam int          OUT_BITS = 40;
    localparam logic [7:0]  CMD      = 8'h0B;
`else
    localparam int          OUT_BITS = 32;
    localparam logic [7:0]  CMD      = 8'h03;
`endif

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [3:0] GAP_LAST  = 4'(CS_IDLE - 1);
    localparam logic [5:0] OUT_LAST  = 6'(OUT_BITS - 1);
    localparam logic [5:0] IN_LAST   = 6'd15;

    typedef enum logic [2:0] {IDLE, SHIFT_OUT, SHIFT_IN, DONE, GAP} state_t;

    state_t                state;
    logic [7:0]            div_cnt;
    logic [5:0]            bit_cnt;
    logic [3:0]            gap_cnt;
    logic [OUT_BITS-1:0]   tx_sr;
    logic [15:0]           rx_sr;
    logic [15:0]           spi_data_r;
    logic                  ready_r;
    logic                  cs_n_r;
    logic                  sclk_r;
    logic                  mosi_r;

    logic tick;
    logic sclk_rise;
    logic sclk_fall;

    function automatic logic [OUT_BITS-1:0] load_word(input logic [23:0] addr);
`ifdef SPI_FLASH_FAST_READ_EN
        return {CMD, addr, 8'h00};
`else
        return {CMD, addr};
`endif
    endfunction

    // One divider tick ends each sclk half-period; the edge it lands on toggles sclk.
    assign tick      = (div_cnt == DIV_LAST);
    assign sclk_rise = tick && !sclk_r;
    assign sclk_fall = tick &&  sclk_r;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            spi_data_r <= '0;
            ready_r    <= 1'b1;
            cs_n_r     <= 1'b1;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
        end else begin
            if (state == SHIFT_OUT || state == SHIFT_IN) begin
                if (tick) begin
                    div_cnt <= '0;
                    sclk_r  <= ~sclk_r;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.spi_rd) begin
                        tx_sr   <= load_word(bus.spi_addr);
                        mosi_r  <= CMD[7];
                        ready_r <= 1'b0;
                        cs_n_r  <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT_OUT;
                    end
                end
                SHIFT_OUT: begin
                    if (sclk_fall) begin
                        tx_sr <= tx_sr << 1;
                        if (bit_cnt == OUT_LAST) begin
                            bit_cnt <= '0;
                            mosi_r  <= 1'b0;
                            state   <= SHIFT_IN;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                            mosi_r  <= tx_sr[OUT_BITS-2];
                        end
                    end
                end
                SHIFT_IN: begin
                    // miso was set up by the flash on the previous falling edge.
                    if (sclk_rise) begin
                        rx_sr <= {rx_sr[14:0], bus.miso};
                    end
                    if (sclk_fall) begin
                        if (bit_cnt == IN_LAST) begin
                            bit_cnt <= '0;
                            state   <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                DONE: begin
                    // First byte on the wire is the low byte of the word.
                    spi_data_r <= {rx_sr[7:0], rx_sr[15:8]};
                    ready_r    <= 1'b1;
                    cs_n_r     <= 1'b1;
                    gap_cnt    <= '0;
                    state      <= GAP;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.spi_data = spi_data_r;
    assign bus.ready    = ready_r;
    assign bus.cs_n     = cs_n_r;
    assign bus.sclk     = sclk_r;
    assign bus.mosi     = mosi_r;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV 1 and 3), each with a behavioural flash.
module tb_spi_flash_reader;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam int         OUT_BITS = 40;
    localparam logic [7:0] CMD      = 8'h0B;
`else
    localparam int         OUT_BITS = 32;
    localparam logic [7:0] CMD      = 8'h03;
`endif
    localparam int LAT_K     = 2 * OUT_BITS + 32;
    localparam int SCK_EDGES = OUT_BITS + 16;

    typedef struct {
        int          g;
        logic [15:0] data;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    exp_t        sb[$];
    logic [7:0]  mem [logic [23:0]];

    logic        rd_d   [2];
    logic [23:0] addr_d [2];
    logic [1:0]  rdy_q = 2'b11;

    wire [1:0]   rdy_o;
    wire [1:0]   cs_o;
    wire [1:0]   sclk_o;
    wire [1:0]   mosi_o;
    wire [15:0]  data_o  [2];
    wire [7:0]   cmd_o   [2];
    wire [23:0]  addr_o  [2];
    wire [7:0]   dummy_o [2];
    wire [31:0]  rises_o [2];
    wire [31:0]  txn_o   [2];
    wire [15:0]  hi_o    [2];
    wire [15:0]  lo_o    [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        return mem.exists(a) ? mem[a] : 8'hFF;
    endfunction

    function automatic logic [15:0] exp_word(input logic [23:0] a);
        return {mem_rd(a + 24'd1), mem_rd(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int DIV = (g == 0) ? 1 : 3;

        spi_flash_reader_if bus();

        spi_flash_reader #(.CLK_DIV(DIV), .CS_IDLE(2)) dut (
            .wb_clk_i (clk),
            .wb_rst_i (rst),
            .bus      (bus.master)
        );

        logic [39:0] in_sr = '0;
        logic [15:0] word;
        logic        miso_r = 1'b0;
        logic        sclk_q = 1'b0;
        logic        cs_q = 1'b1;
        logic        cs_q2 = 1'b1;
        logic        ph_q = 1'b0;
        int          rx_n = 0;
        int          tx_n = 0;
        int          rises = 0;
        int          txn = 0;
        int          run = 0;
        logic [7:0]  hi_min = 8'hFF, hi_max = 8'h00, lo_min = 8'hFF, lo_max = 8'h00;

        assign bus.spi_addr = addr_d[g];
        assign bus.spi_rd   = rd_d[g];
        assign bus.miso     = miso_r;
        assign rdy_o[g]     = bus.ready;
        assign cs_o[g]      = bus.cs_n;
        assign sclk_o[g]    = bus.sclk;
        assign mosi_o[g]    = bus.mosi;
        assign data_o[g]    = bus.spi_data;
        assign cmd_o[g]     = in_sr[OUT_BITS-1 -: 8];
        assign addr_o[g]    = in_sr[OUT_BITS-9 -: 24];
        assign dummy_o[g]   = in_sr[7:0];
        assign rises_o[g]   = rises;
        assign txn_o[g]     = txn;
        assign hi_o[g]      = {hi_min, hi_max};
        assign lo_o[g]      = {lo_min, lo_max};

        // Flash: samples mosi on rising sclk, drives data MSB first from each falling sclk.
        always @(bus.sclk or bus.cs_n) begin
            if (!bus.cs_n && cs_q) begin
                rx_n = 0; tx_n = 0; rises = 0; in_sr = '0; miso_r = 1'b0;
                txn++;
            end
            if (!bus.cs_n) begin
                if (bus.sclk && !sclk_q) begin
                    rises++;
                    if (rx_n < OUT_BITS) begin
                        in_sr = {in_sr[38:0], bus.mosi};
                        rx_n++;
                    end
                end else if (!bus.sclk && sclk_q && rx_n == OUT_BITS && tx_n < 16) begin
                    word   = {mem_rd(in_sr[OUT_BITS-9 -: 24]), mem_rd(in_sr[OUT_BITS-9 -: 24] + 24'd1)};
                    miso_r = word[4'(15 - tx_n)];
                    tx_n++;
                end
            end
            sclk_q = bus.sclk;
            cs_q   = bus.cs_n;
        end

        // sclk phase lengths in clk cycles while cs_n is low.
        always @(negedge clk) begin
            if (!bus.cs_n) begin
                if (cs_q2) begin
                    hi_min = 8'hFF; hi_max = 8'h00; lo_min = 8'hFF; lo_max = 8'h00;
                    run = 0; ph_q = 1'b0;
                end
                if (bus.sclk == ph_q) begin
                    run++;
                end else begin
                    if (ph_q) begin
                        if (8'(run) < hi_min) hi_min = 8'(run);
                        if (8'(run) > hi_max) hi_max = 8'(run);
                    end else begin
                        if (8'(run) < lo_min) lo_min = 8'(run);
                        if (8'(run) > lo_max) lo_max = 8'(run);
                    end
                    run = 1;
                end
                ph_q = bus.sclk;
            end
            cs_q2 = bus.cs_n;
        end
    end

    // Scoreboard consumer: every rising ready outside reset must match a queued read.
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 2; g++) begin
            if (!rst && rdy_o[g] && !rdy_q[g]) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(g + 1), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_inst", 32'(g), 32'(e.g));
                    chk("sb_data", {16'h0, data_o[g]}, {16'h0, e.data});
                    chk("sb_latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
            rdy_q[g] = rst ? 1'b1 : rdy_o[g];
        end
    end

    // Call just after a negedge; the next posedge is the accepting edge.
    task automatic issue(input int g, input logic [23:0] a, input bit push);
        exp_t e;
        addr_d[g] = a;
        rd_d[g]   = 1'b1;
        if (push) begin
            e.g    = g;
            e.data = exp_word(a);
            e.acc  = cyc + 1;
            e.lat  = LAT_K * ((g == 0) ? 1 : 3) + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        rd_d[g] = 1'b0;
    endtask

    task automatic wait_ready(input int g, input int budget);
        int n = 0;
        while (rdy_o[g] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (rdy_o[g] !== 1'b1) chk("ready_timeout", {31'h0, rdy_o[g]}, 32'd1);
    endtask

    task automatic check_frame(input int g, input string tag, input logic [23:0] a, input int div);
        chk({tag, "_cmd"}, {24'h0, cmd_o[g]}, {24'h0, CMD});
        chk({tag, "_addr"}, {8'h0, addr_o[g]}, {8'h0, a});
`ifdef SPI_FLASH_FAST_READ_EN
        chk({tag, "_dummy"}, {24'h0, dummy_o[g]}, 32'd0);
`endif
        chk({tag, "_sck_rises"}, rises_o[g], 32'(SCK_EDGES));
        chk({tag, "_sck_high"}, {16'h0, hi_o[g]}, {16'h0, 8'(div), 8'(div)});
        chk({tag, "_sck_low"}, {16'h0, lo_o[g]}, {16'h0, 8'(div), 8'(div)});
    endtask

    initial begin
        int tx0;
        mem[24'h100000] = 8'h34; mem[24'h100001] = 8'h12;
        mem[24'h000000] = 8'h11; mem[24'h000001] = 8'h22;
        mem[24'h000002] = 8'h5A; mem[24'h000003] = 8'hA5;
        mem[24'h000010] = 8'h77; mem[24'h000011] = 8'h66;
        mem[24'h008000] = 8'hEF; mem[24'h008001] = 8'hBE;
        for (int g = 0; g < 2; g++) begin
            rd_d[g]   = 1'b0;
            addr_d[g] = '0;
        end

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", {31'h0, rdy_o[0]}, 32'd1);
        chk("rst_cs_n", {31'h0, cs_o[0]}, 32'd1);
        chk("rst_sclk", {31'h0, sclk_o[0]}, 32'd0);
        chk("rst_mosi", {31'h0, mosi_o[0]}, 32'd0);
        chk("rst_data", {16'h0, data_o[0]}, 32'd0);
        chk("rst_ready1", {31'h0, rdy_o[1]}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic read.
        issue(0, 24'h100000, 1'b1);
        wait_ready(0, 400);
        check_frame(0, "basic", 24'h100000, 1);
        repeat (4) @(negedge clk);

        // Requests while busy and during the cs_n gap are dropped.
        tx0 = txn_o[0];
        issue(0, 24'h000000, 1'b1);
        repeat (19) @(negedge clk);
        issue(0, 24'h000010, 1'b0);
        wait_ready(0, 400);
        issue(0, 24'h000010, 1'b0);
        repeat (10) @(negedge clk);
        chk("busy_cs_pulses", 32'(txn_o[0] - tx0), 32'd1);
        chk("busy_ready", {31'h0, rdy_o[0]}, 32'd1);
        chk("busy_data", {16'h0, data_o[0]}, 32'h2211);
        chk("busy_addr", {8'h0, addr_o[0]}, 32'h000000);

        // Divided sclk.
        issue(1, 24'h008000, 1'b1);
        wait_ready(1, 1000);
        check_frame(1, "div3", 24'h008000, 3);
        repeat (4) @(negedge clk);

        // Reset during the data phase.
        issue(0, 24'h000002, 1'b1);
        repeat (2 * OUT_BITS + 8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_cs_n", {31'h0, cs_o[0]}, 32'd1);
        chk("midrst_sclk", {31'h0, sclk_o[0]}, 32'd0);
        chk("midrst_mosi", {31'h0, mosi_o[0]}, 32'd0);
        chk("midrst_ready", {31'h0, rdy_o[0]}, 32'd1);
        chk("midrst_data", {16'h0, data_o[0]}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        issue(0, 24'h000002, 1'b1);
        wait_ready(0, 400);
        check_frame(0, "post_rst", 24'h000002, 1);
        chk("post_rst_data", {16'h0, data_o[0]}, 32'hA55A);
        repeat (4) @(negedge clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
